// File: rtl/mips_cpu_pkg.sv
// Shared load-unit types: op encoding, FSM states, latched request and the
// byte-lane extract/extend/merge function used by load_data_align.
package mips_cpu_pkg;

    typedef enum logic [2:0] {
        LB      = 3'd0,
        LBU     = 3'd1,
        LH      = 3'd2,
        LHU     = 3'd3,
        LW      = 3'd4,
        LWL     = 3'd5,
        LWR     = 3'd6,
        LOP_ILL = 3'd7
    } load_op_t;

    typedef enum logic [1:0] {IDLE, REQ, WB, ERR} state_t;

    typedef struct packed {
        load_op_t    op;
        logic [31:0] addr;
        logic [4:0]  rt_index;
        logic [31:0] rt_old;
    } load_req_t;

    // o is the byte offset within the word; lanes are little-endian.
    function automatic logic [31:0] load_extend(input load_op_t op, input logic [1:0] o,
                                                input logic [31:0] word,
                                                input logic [31:0] rt_old);
        logic [7:0]  b;
        logic [15:0] h;
        logic [4:0]  sh;
        logic [4:0]  sh_l;
        logic [31:0] r;
        sh   = {o, 3'b000};
        sh_l = {~o, 3'b000};
        b    = word[sh +: 8];
        h    = word[{o[1], 4'b0000} +: 16];
        case (op)
            LB:      r = {{24{b[7]}}, b};
            LBU:     r = {24'd0, b};
            LH:      r = {{16{h[15]}}, h};
            LHU:     r = {16'd0, h};
            // LWL keeps the low 3-o bytes of rt_old; LWR keeps the high o bytes.
            LWL:     r = (word << sh_l) | (rt_old & ((32'hFFFF_FFFF >> sh) >> 8));
            LWR:     r = (word >> sh) | (rt_old & ~(32'hFFFF_FFFF >> sh));
            default: r = word;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/load_data_align.sv
// Combinational write-data former: picks the addressed lane(s) of the
// returned word and extends them or merges them into the old rt value.
module load_data_align
    import mips_cpu_pkg::*;
(
    input  load_op_t    op,
    input  logic [1:0]  o,
    input  logic [31:0] word,
    input  logic [31:0] rt_old,
    output logic [31:0] write_data
);

    always_comb write_data = load_extend(op, o, word, rt_old);

endmodule

// File: rtl/load_writeback.sv
// Multi-cycle load unit: one bus word read per load, then one register-file write.
// Define MIPS_LOAD_UNALIGNED_EN to accept LWL/LWR; otherwise they raise error.
module load_writeback
    import mips_cpu_pkg::*;
#(
    parameter int unsigned WAIT_MAX = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] addr,
    input  logic [4:0]  rt_index,
    input  logic [31:0] rt_old,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic [3:0]  mem_byteenable,
    input  logic [31:0] mem_readdata,
    input  logic        mem_waitrequest,
    output logic [4:0]  write_index,
    output logic        write_enable,
    output logic [31:0] write_data
);

    state_t      state_q, state_d;
    load_req_t   req_q, req_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] wait_cnt_q, wait_cnt_d;
    logic        legal;
    logic        timeout;
    logic [31:0] aligned_data;

    always_comb begin
        legal = 1'b0;
        case (load_op_t'(op))
            LB, LBU:  legal = 1'b1;
            LH, LHU:  legal = ~addr[0];
            LW:       legal = (addr[1:0] == 2'b00);
`ifdef MIPS_LOAD_UNALIGNED_EN
            LWL, LWR: legal = 1'b1;
`endif
            default:  legal = 1'b0;
        endcase
    end

    // Counter holds the number of stalled REQ cycles already seen.
    always_comb timeout = (WAIT_MAX != 0) && mem_waitrequest && (wait_cnt_q == WAIT_MAX - 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            req_q      <= '0;
            rdata_q    <= '0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            rdata_q    <= rdata_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = legal ? REQ : ERR;
            REQ: begin
                if (!mem_waitrequest) state_d = WB;
                else if (timeout)     state_d = ERR;
            end
            WB:      state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_d      = req_q;
        rdata_d    = rdata_q;
        wait_cnt_d = '0;
        if (state_q == IDLE && start)
            req_d = '{op: load_op_t'(op), addr: addr, rt_index: rt_index, rt_old: rt_old};
        if (state_q == REQ) begin
            if (!mem_waitrequest) rdata_d = mem_readdata;
            else                  wait_cnt_d = wait_cnt_q + 32'd1;
        end
    end

    load_data_align u_align (
        .op         (req_q.op),
        .o          (req_q.addr[1:0]),
        .word       (rdata_q),
        .rt_old     (req_q.rt_old),
        .write_data (aligned_data)
    );

    always_comb begin
        busy           = 1'b0;
        done           = 1'b0;
        error          = 1'b0;
        mem_address    = '0;
        mem_read       = 1'b0;
        mem_byteenable = '0;
        write_index    = '0;
        write_enable   = 1'b0;
        write_data     = '0;
        case (state_q)
            REQ: begin
                busy           = 1'b1;
                mem_read       = 1'b1;
                mem_address    = {req_q.addr[31:2], 2'b00};
                mem_byteenable = 4'b1111;
            end
            WB: begin
                busy         = 1'b1;
                done         = 1'b1;
                write_index  = req_q.rt_index;
                write_enable = (req_q.rt_index != 5'd0);
                write_data   = aligned_data;
            end
            ERR:     error = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_load_writeback.sv
// Directed table-driven bench for load_writeback plus timeout and reset sequences.
module tb_load_writeback;
    import mips_cpu_pkg::*;

`ifdef MIPS_LOAD_UNALIGNED_EN
    localparam bit UNAL = 1'b1;
`else
    localparam bit UNAL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [4:0]  rt_index;
    logic [31:0] rt_old;
    logic [31:0] mem_readdata;
    logic        mem_waitrequest;

    logic        busy, done, error, mem_read, write_enable;
    logic [31:0] mem_address, write_data;
    logic [3:0]  mem_byteenable;
    logic [4:0]  write_index;

    logic        i_busy, i_done, i_error, i_mem_read, i_write_enable;
    logic [31:0] i_mem_address, i_write_data;
    logic [3:0]  i_mem_byteenable;
    logic [4:0]  i_write_index;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    load_writeback #(.WAIT_MAX(4)) u_dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .addr(addr),
        .rt_index(rt_index), .rt_old(rt_old), .busy(busy), .done(done), .error(error),
        .mem_address(mem_address), .mem_read(mem_read), .mem_byteenable(mem_byteenable),
        .mem_readdata(mem_readdata), .mem_waitrequest(mem_waitrequest),
        .write_index(write_index), .write_enable(write_enable), .write_data(write_data)
    );

    load_writeback #(.WAIT_MAX(0)) u_inf (
        .clk(clk), .reset(reset), .start(start), .op(op), .addr(addr),
        .rt_index(rt_index), .rt_old(rt_old), .busy(i_busy), .done(i_done), .error(i_error),
        .mem_address(i_mem_address), .mem_read(i_mem_read), .mem_byteenable(i_mem_byteenable),
        .mem_readdata(mem_readdata), .mem_waitrequest(mem_waitrequest),
        .write_index(i_write_index), .write_enable(i_write_enable), .write_data(i_write_data)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [4:0]  rt;
        logic [31:0] rt_old;
        logic [31:0] word;
        int          waits;
        logic        exp_err;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string nm;
        nm = $sformatf("v%0d", idx);
        @(negedge clk);
        start = 1'b1; op = v.op; addr = v.addr; rt_index = v.rt; rt_old = v.rt_old;
        mem_waitrequest = 1'b1; mem_readdata = 32'hBAD0_BAD0;
        @(negedge clk);
        start = 1'b0; op = 3'd0; addr = 32'hFFFF_FFFF; rt_index = 5'd31; rt_old = 32'h0;
        if (v.exp_err) begin
            chk({nm, " error"}, 32'(error), 32'd1);
            chk({nm, " mem_read"}, 32'(mem_read), 32'd0);
            chk({nm, " busy"}, 32'(busy), 32'd0);
            chk({nm, " we"}, 32'(write_enable), 32'd0);
        end else begin
            for (int w = 0; w <= v.waits; w++) begin
                chk({nm, " mem_read"}, 32'(mem_read), 32'd1);
                chk({nm, " mem_address"}, mem_address, {v.addr[31:2], 2'b00});
                chk({nm, " byteenable"}, 32'(mem_byteenable), 32'hF);
                chk({nm, " early we"}, 32'(write_enable), 32'd0);
                // stray requests while busy must be dropped, not queued
                start = (w == 1);
                op = 3'(LH); addr = 32'h0000_0001;
                mem_waitrequest = (w < v.waits);
                mem_readdata = (w < v.waits) ? 32'hBAD0_BAD0 : v.word;
                @(negedge clk);
            end
            start = 1'b0; mem_waitrequest = 1'b1; mem_readdata = 32'hBAD0_BAD0;
            chk({nm, " done"}, 32'(done), 32'd1);
            chk({nm, " busy wb"}, 32'(busy), 32'd1);
            chk({nm, " we"}, 32'(write_enable), 32'(v.rt != 5'd0));
            if (v.rt != 5'd0) begin
                chk({nm, " widx"}, 32'(write_index), 32'(v.rt));
                chk({nm, " wdata"}, write_data, v.exp_data);
            end
        end
        @(negedge clk);
        chk({nm, " idle busy"}, 32'(busy), 32'd0);
        chk({nm, " idle done"}, 32'(done), 32'd0);
        chk({nm, " idle error"}, 32'(error), 32'd0);
        chk({nm, " idle mem_read"}, 32'(mem_read), 32'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 3'd0; addr = 32'd0; rt_index = 5'd0; rt_old = 32'd0;
        mem_readdata = 32'd0; mem_waitrequest = 1'b0;

        vecs.push_back('{3'(LB),  32'h1003, 5'd5, 32'h0, 32'h8011_2233, 0, 1'b0, 32'hFFFF_FF80});
        vecs.push_back('{3'(LBU), 32'h1003, 5'd5, 32'h0, 32'h8011_2233, 0, 1'b0, 32'h0000_0080});
        vecs.push_back('{3'(LW),  32'h2000, 5'd7, 32'h0, 32'hDEAD_BEEF, 3, 1'b0, 32'hDEAD_BEEF});
        vecs.push_back('{3'(LH),  32'h2001, 5'd7, 32'h0, 32'h1234_5678, 0, 1'b1, 32'h0});
        vecs.push_back('{3'(LW),  32'h2004, 5'd0, 32'h0, 32'h1234_5678, 0, 1'b0, 32'h0});
        vecs.push_back('{3'(LH),  32'h1002, 5'd9, 32'h0, 32'h8011_2233, 1, 1'b0, 32'hFFFF_8011});
        vecs.push_back('{3'(LHU), 32'h1000, 5'd9, 32'h0, 32'h1234_F00D, 0, 1'b0, 32'h0000_F00D});
        vecs.push_back('{3'(LB),  32'h1001, 5'd1, 32'h0, 32'h1122_7F33, 0, 1'b0, 32'h0000_007F});
        vecs.push_back('{3'(LBU), 32'h1002, 5'd2, 32'h0, 32'h8011_2233, 2, 1'b0, 32'h0000_0011});
        vecs.push_back('{3'(LW),  32'h1002, 5'd3, 32'h0, 32'h1234_5678, 0, 1'b1, 32'h0});
        vecs.push_back('{3'd7,    32'h1000, 5'd3, 32'h0, 32'h1234_5678, 0, 1'b1, 32'h0});
        vecs.push_back('{3'(LWL), 32'h3001, 5'd4, 32'hAABB_CCDD, 32'h1122_3344, 0, !UNAL, 32'h3344_CCDD});
        vecs.push_back('{3'(LWR), 32'h3001, 5'd4, 32'hAABB_CCDD, 32'h1122_3344, 0, !UNAL, 32'hAA11_2233});
        vecs.push_back('{3'(LWL), 32'h3000, 5'd4, 32'hAABB_CCDD, 32'h1122_3344, 1, !UNAL, 32'h44BB_CCDD});
        vecs.push_back('{3'(LWR), 32'h3003, 5'd4, 32'hAABB_CCDD, 32'h1122_3344, 0, !UNAL, 32'hAABB_CC11});

        repeat (2) @(negedge clk);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset mem_read", 32'(mem_read), 32'd0);
        chk("reset we", 32'(write_enable), 32'd0);
        chk("reset addr", mem_address, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

        // Stuck bus: WAIT_MAX=4 instance aborts, WAIT_MAX=0 instance keeps waiting.
        @(negedge clk);
        start = 1'b1; op = 3'(LW); addr = 32'h4000; rt_index = 5'd3; mem_waitrequest = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            chk($sformatf("to req%0d mem_read", c), 32'(mem_read), 32'd1);
            chk($sformatf("to req%0d error", c), 32'(error), 32'd0);
            @(negedge clk);
        end
        chk("to error", 32'(error), 32'd1);
        chk("to mem_read", 32'(mem_read), 32'd0);
        chk("to we", 32'(write_enable), 32'd0);
        chk("inf busy", 32'(i_busy), 32'd1);
        chk("inf mem_read", 32'(i_mem_read), 32'd1);
        @(negedge clk);
        chk("to idle busy", 32'(busy), 32'd0);
        chk("to idle error", 32'(error), 32'd0);
        chk("inf still busy", 32'(i_busy), 32'd1);

        // Reset while both instances sit in REQ with the bus stalled.
        start = 1'b1; op = 3'(LW); addr = 32'h5000; rt_index = 5'd6;
        @(negedge clk);
        start = 1'b0;
        chk("rst pre mem_read", 32'(mem_read), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst mem_read", 32'(mem_read), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst inf mem_read", 32'(i_mem_read), 32'd0);
        chk("rst inf busy", 32'(i_busy), 32'd0);
        chk("rst we", 32'(write_enable | i_write_enable), 32'd0);
        reset = 1'b0;
        mem_waitrequest = 1'b0;
        @(negedge clk);
        chk("post rst we", 32'(write_enable | i_write_enable), 32'd0);
        chk("post rst busy", 32'(busy | i_busy), 32'd0);

        run_vec('{3'(LW), 32'h6000, 5'd8, 32'h0, 32'hCAFE_F00D, 0, 1'b0, 32'hCAFE_F00D}, 99);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
